// File: rtl/input_feed_scheduler.sv
// input_feed_scheduler: issues row-0 read strobes for the skewed input buffer, tile by tile, with weight handshake, stall and skew drain
module input_feed_scheduler #(
  parameter int SYS_ROWS = 4,
  parameter int A_ROWS   = 16,
  parameter int TW       = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [TW-1:0] num_tiles,
  input  logic          w_ready,
  input  logic          stall,
  output logic          read,
  output logic          feed_last,
  output logic [TW-1:0] tile_idx,
  output logic          busy,
  output logic          done
);
  localparam int RW = A_ROWS > 1 ? $clog2(A_ROWS) : 1;
  localparam int DW = $clog2(SYS_ROWS);
  localparam logic [RW-1:0] ROW_LAST   = RW'(A_ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(SYS_ROWS - 2);
  typedef enum logic [2:0] {IDLE, WAIT_W, FEED, DRAIN, DONE} state_t;
  state_t        state, state_n;
  logic [RW-1:0] row_cnt;
  logic [DW-1:0] drain_cnt;
  logic [TW-1:0] tiles;
  logic          drain_end, last_tile;
  assign read      = state == FEED && !stall;
  assign feed_last = read && row_cnt == ROW_LAST;
  assign drain_end = state == DRAIN && drain_cnt == DRAIN_LAST;
  assign last_tile = tile_idx == tiles - 1'b1;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  // next-state: stall only matters in FEED, the skew drain runs a fixed length
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (num_tiles == '0 ? DONE : WAIT_W) : IDLE;
      WAIT_W:  state_n = w_ready ? FEED : WAIT_W;
      FEED:    state_n = feed_last ? DRAIN : FEED;
      DRAIN:   state_n = drain_end ? (last_tile ? DONE : WAIT_W) : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // state register, job latch and row/drain/tile counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      tile_idx  <= '0;
      tiles     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        tiles    <= num_tiles;
        tile_idx <= '0;
      end
      if (state == WAIT_W && w_ready) row_cnt <= '0;
      else if (read) row_cnt <= row_cnt + 1'b1;
      if (feed_last) drain_cnt <= '0;
      else if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      if (drain_end && !last_tile) tile_idx <= tile_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_input_feed_scheduler.sv
// tb_input_feed_scheduler: table-driven jobs with a feed_last scoreboard plus hand-written reset sequences
module tb_input_feed_scheduler;
  localparam int A_ROWS = 16;
  localparam int SYS_ROWS = 4;
  localparam int TW = 8;
  logic clk = 0, rstn = 0, start = 0, w_ready = 1, stall = 0;
  logic [TW-1:0] num_tiles = '0;
  logic read, feed_last, busy, done;
  logic [TW-1:0] tile_idx;
  int errors = 0, checks = 0;

  input_feed_scheduler #(.SYS_ROWS(SYS_ROWS), .A_ROWS(A_ROWS), .TW(TW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles), .w_ready(w_ready),
    .stall(stall), .read(read), .feed_last(feed_last), .tile_idx(tile_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    int          wlow;
    int          extra;
    int          exp_done;
    int          sp;
    logic [63:0] smap;
  } vec_t;
  typedef struct {
    int cyc;
    int t;
  } exp_t;
  vec_t tv[6];
  exp_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int c, reads, treads, busy_n, p;
    bit got;
    exp_t e;
    c = 0; reads = 0; treads = 0; busy_n = 0; got = 0;
    p = v.wlow + 1 + A_ROWS + SYS_ROWS - 1;
    q.delete();
    for (int t = 0; t < v.n; t++) q.push_back('{t * p + v.wlow + 1 + A_ROWS + v.extra, t});
    @(posedge clk); #1;
    start = 1; num_tiles = TW'(v.n); stall = v.smap[0]; w_ready = 1;
    while (c < v.exp_done + 50) begin
      @(negedge clk);
      if (read) begin reads++; treads++; end
      if (busy) busy_n++;
      if (stall) chk("read_under_stall", int'(read), 0);
      if (feed_last) begin
        if (q.size() == 0) chk("unexpected_feed_last", c, -1);
        else begin
          e = q.pop_front();
          chk("feed_last_cycle", c, e.cyc);
          chk("feed_last_tile", int'(tile_idx), e.t);
          chk("reads_per_tile", treads, A_ROWS);
        end
        treads = 0;
      end
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
      c++;
      start = (c == v.sp);
      num_tiles = (c == 0) ? TW'(v.n) : TW'(7);
      stall = (c < 64) ? v.smap[c] : 1'b0;
      w_ready = !(c >= 1 && (c - 1) % p < v.wlow);
    end
    chk("done_seen", int'(got), 1);
    chk("done_cycle", c, v.exp_done);
    chk("total_reads", reads, v.n * A_ROWS);
    chk("busy_cycles", busy_n, v.exp_done);
    chk("pending_tiles", q.size(), 0);
    chk("final_tile_idx", int'(tile_idx), v.n > 0 ? v.n - 1 : 0);
    @(posedge clk); #1;
    start = 0; stall = 0; w_ready = 1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_tile_idx_held", int'(tile_idx), v.n > 0 ? v.n - 1 : 0);
  endtask

  initial begin
    tv[0] = '{1, 0, 0, 21, -1, 64'h0};
    tv[1] = '{1, 0, 3, 24, -1, (64'h7 << 5) | (64'h3 << 21)};
    tv[2] = '{3, 5, 0, 76, -1, 64'h0};
    tv[3] = '{0, 0, 0, 1, -1, 64'h0};
    tv[4] = '{1, 0, 0, 21, 6, 64'h0};
    tv[5] = '{255, 0, 0, 5101, -1, 64'h0};
    #12;
    chk("rst_read", int'(read), 0);
    chk("rst_feed_last", int'(feed_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tile_idx", int'(tile_idx), 0);
    @(negedge clk); rstn = 1;
    for (int i = 0; i < 6; i++) run(tv[i]);
    @(posedge clk); #1;
    start = 1; num_tiles = 1; w_ready = 1; stall = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_feed_read", int'(read), 1);
    rstn = 0;
    #1;
    chk("async_rst_read", int'(read), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_tile_idx", int'(tile_idx), 0);
    @(negedge clk); rstn = 1;
    run(tv[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_feed_scheduler.md
Name: input_feed_scheduler

Overview:
- Sequences the skewed row-FIFO input buffer that feeds the systolic array.
- Issues the row-0 `read` strobe for one tile of A_ROWS words at a time; the buffer propagates the read skew to the other rows itself.
- Waits for the array's weight-load handshake before each tile, and pauses feeding on downstream stall.
- Drains the skew after each tile, iterates over a programmed tile count, and reports completion.

Parameters:
- SYS_ROWS, 4, systolic array rows = input buffer FIFO count; must be >= 2.
- A_ROWS, 16, words streamed per FIFO per tile (super-A rows).
- TW, 8, width of the tile counter and `num_tiles`.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle launch request; honoured only in IDLE.
- num_tiles  in  TW  tiles to stream; sampled when `start` is accepted.
- w_ready  in  1  array has weights loaded for the next tile.
- stall  in  1  downstream back-pressure; suppresses `read` while in FEED.
- read  out  1  read strobe to input buffer row 0.
- feed_last  out  1  high coincident with the final `read` of a tile.
- tile_idx  out  TW  index of the tile currently being fed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the whole job completes.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; row_cnt=0, drain_cnt=0, tile_idx=0, latched tile count=0. Therefore read=0, feed_last=0, busy=0, done=0.
- Reset mid-job aborts immediately; there is no recovery of partial tiles.
- States: IDLE, WAIT_W, FEED, DRAIN, DONE. All are registered.
- `read` = (state==FEED) & ~stall. It is combinational from registered state and `stall`. This is the only combinational input-to-output path.
- IDLE:
  - On start=1, latch num_tiles and clear tile_idx.
  - If num_tiles==0, go to DONE; otherwise go to WAIT_W.
  - `start` in any other state is ignored with no side effects.
- WAIT_W:
  - When w_ready=1, go to FEED next cycle and clear row_cnt.
  - Otherwise hold indefinitely.
- FEED:
  - row_cnt increments only on cycles with read=1; stall cycles hold row_cnt and state.
  - feed_last = read & (row_cnt==A_ROWS-1).
  - On feed_last, go to DRAIN and clear drain_cnt.
  - Exactly A_ROWS reads per tile, regardless of the stall pattern.
- DRAIN:
  - Lasts exactly SYS_ROWS-1 cycles, covering the valid skew to the last FIFO.
  - `stall` is ignored here, because the skew chain cannot pause.
  - After the last drain cycle:
    - if tile_idx==latched_count-1, go to DONE;
    - else increment tile_idx and go to WAIT_W.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - tile_idx holds its last value until the next accepted `start`.
- Timing: w_ready is sampled in WAIT_W only. w_ready dropping during FEED/DRAIN has no effect.
- Minimum tile period with no stall and w_ready=1 is 1 + A_ROWS + (SYS_ROWS-1) cycles.
- row_cnt must be at least clog2(A_ROWS) bits. drain_cnt must be at least clog2(SYS_ROWS) bits. Comparisons are unsigned; there is no wrap within a tile.
- num_tiles = 2^TW-1 must complete with no tile_idx overflow.

Test Plan (defaults SYS_ROWS=4, A_ROWS=16):
1. Single tile: w_ready=1, start with num_tiles=1 at cycle 0.
   - WAIT_W at cycle 1; read high cycles 2–17; feed_last at 17.
   - DRAIN cycles 18–20; done at 21; busy low at 22.
2. Stall: as test 1, with stall=1 on cycles 5–7.
   - read low on cycles 5–7; 16 reads total; feed_last at 20; done at 24.
   - stall=1 during DRAIN changes nothing.
3. Multi-tile with weight handshake: num_tiles=3, w_ready low for 5 cycles after each DRAIN.
   - Each tile has exactly 16 reads; tile_idx steps 0,1,2.
   - No read while in WAIT_W; done pulses once.
4. Zero tiles: start with num_tiles=0 at cycle 0.
   - done at cycle 1; read never asserted; busy high only at cycle 1.
5. Ignored start and async reset:
   - A start pulse during FEED leaves tile_idx and row_cnt unchanged.
   - rstn low mid-FEED forces read=0 and busy=0 within the same cycle.
   - A fresh start after reset runs identically to test 1.
